// File: rtl/matrix_pkg.sv
// ============================================================================
// Module   : matrix_pkg
// Brief    : Shared sizes, diagonal indices and loader state for the 5x5
//            matrix loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package matrix_pkg;

  localparam int MAT_N     = 5;
  localparam int MAT_W     = 16;
  localparam int MAT_ELEMS = MAT_N * MAT_N;
  localparam int MAT_BUS_W = MAT_ELEMS * MAT_W;

  // Row-major positions of the pivots: k = i*(N+1)
  localparam int DIAG_IDX [MAT_N] = '{0, 6, 12, 18, 24};

  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/matrix_diag_check.sv
// ============================================================================
// Module   : matrix_diag_check
// Brief    : Combinational zero-pivot detector over a flat 5x5 matrix bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_diag_check
  import matrix_pkg::*;
(
  input  logic [MAT_BUS_W-1:0] i_mat,
  output logic                 o_zero_pivot
);

  always_comb begin
    o_zero_pivot = 1'b0;
    for (int i = 0; i < MAT_N; i++) begin
      if (i_mat[DIAG_IDX[i]*MAT_W +: MAT_W] == '0) begin
        o_zero_pivot = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/matrix_loader.sv
// ============================================================================
// Module   : matrix_loader
// Brief    : Collects a row-major stream of 25 elements into one buffer and
//            presents it as a 400-bit matrix with valid/ready handoff.
//            Optional zero-pivot flag: MATRIX_LOADER_DIAG_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_loader
  import matrix_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAT_W-1:0]     in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAT_BUS_W-1:0] out_matrix,
  output logic                 frame_err,
  output logic                 diag_zero
);

  localparam logic [4:0] C_LAST_SLOT = 5'(MAT_ELEMS - 1);

  loader_state_t    state_q, state_d;
  logic [4:0]       count_q, count_d;
  logic [MAT_W-1:0] buf_q [MAT_ELEMS];
  logic [MAT_W-1:0] buf_d [MAT_ELEMS];
  logic             frame_err_q, frame_err_d;

  logic w_accept;
  logic w_at_last_slot;
  logic w_frame_bad;
  logic w_done;
  logic w_handshake;

  assign in_ready       = (state_q == FILL) && !reset;
  assign out_valid      = (state_q == FULL);
  assign frame_err      = frame_err_q;

  assign w_accept       = in_valid && in_ready;
  assign w_at_last_slot = (count_q == C_LAST_SLOT);
  // in_last must coincide exactly with slot 24; either mismatch is a framing error
  assign w_frame_bad    = w_accept && (in_last != w_at_last_slot);
  assign w_done         = w_accept && in_last && w_at_last_slot;
  assign w_handshake    = (state_q == FULL) && out_ready;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    frame_err_d = 1'b0;
    buf_d       = buf_q;
    case (state_q)
      FILL: begin
        if (w_frame_bad) begin
          count_d     = '0;
          frame_err_d = 1'b1;
        end else if (w_accept) begin
          buf_d[count_q] = in_data;
          if (w_done) begin
            state_d = FULL;
            count_d = '0;
          end else begin
            count_d = count_q + 5'd1;
          end
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= FILL;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      for (int k = 0; k < MAT_ELEMS; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      buf_q       <= buf_d;
    end
  end

  for (genvar k = 0; k < MAT_ELEMS; k++) begin : g_flat
    assign out_matrix[k*MAT_W +: MAT_W] = buf_q[k];
  end

`ifdef MATRIX_LOADER_DIAG_CHECK_EN
  logic [MAT_BUS_W-1:0] w_buf_next_flat;
  logic                 w_zero_pivot;
  logic                 diag_zero_q, diag_zero_d;

  for (genvar k = 0; k < MAT_ELEMS; k++) begin : g_next_flat
    assign w_buf_next_flat[k*MAT_W +: MAT_W] = buf_d[k];
  end

  // Checked on the post-write buffer so the flag lands together with out_valid
  matrix_diag_check u_diag_check (
    .i_mat        (w_buf_next_flat),
    .o_zero_pivot (w_zero_pivot)
  );

  always_comb begin
    diag_zero_d = diag_zero_q;
    if (w_done) begin
      diag_zero_d = w_zero_pivot;
    end else if (w_handshake) begin
      diag_zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      diag_zero_q <= 1'b0;
    end else begin
      diag_zero_q <= diag_zero_d;
    end
  end

  assign diag_zero = diag_zero_q;
`else
  assign diag_zero = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
// Module   : tb_matrix_loader
// Brief    : Directed self-checking bench for matrix_loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_loader;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [399:0] out_matrix;
  logic         frame_err;
  logic         diag_zero;

  int checks;
  int errors;

  logic [15:0]  elem [25];
  logic [399:0] exp_mat;
  logic         exp_dz;

  matrix_loader dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_matrix (out_matrix),
    .frame_err  (frame_err),
    .diag_zero  (diag_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Stream elem[0..24]; in_last on element 24 only when requested
  task automatic send_matrix(input logic with_last);
    for (int k = 0; k < 25; k++) begin
      send(elem[k], with_last && (k == 24));
    end
  endtask

  task automatic build_exp();
    for (int k = 0; k < 25; k++) begin
      exp_mat[k*16 +: 16] = elem[k];
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready",   400'(in_ready),  400'(0));
    chk("rst_out_valid",  400'(out_valid), 400'(0));
    chk("rst_out_matrix", out_matrix,      '0);
    chk("rst_frame_err",  400'(frame_err), 400'(0));
    chk("rst_diag_zero",  400'(diag_zero), 400'(0));
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 400'(in_ready), 400'(1));

    // Identity matrix with out_ready held high
    for (int k = 0; k < 25; k++) elem[k] = (k % 6 == 0) ? 16'd1 : 16'd0;
    build_exp();
    out_ready = 1'b1;
    send_matrix(1'b1);
    chk("id_out_valid", 400'(out_valid),          400'(1));
    chk("id_el0",       400'(out_matrix[15:0]),   400'(1));
    chk("id_el6",       400'(out_matrix[111:96]), 400'(1));
    chk("id_matrix",    out_matrix,               exp_mat);
    chk("id_frame_err", 400'(frame_err),          400'(0));
    chk("id_diag_zero", 400'(diag_zero),          400'(0));
    chk("id_in_ready",  400'(in_ready),           400'(0));
    tick();
    chk("id_hs_out_valid", 400'(out_valid), 400'(0));
    chk("id_hs_in_ready",  400'(in_ready),  400'(1));

    // Backpressure: hold out_ready low for 10 cycles while junk is offered
    for (int k = 0; k < 25; k++) elem[k] = 16'(k + 1);
    build_exp();
    out_ready = 1'b0;
    send_matrix(1'b1);
    for (int c = 0; c < 10; c++) begin
      chk("bp_out_valid", 400'(out_valid), 400'(1));
      chk("bp_matrix",    out_matrix,      exp_mat);
      chk("bp_in_ready",  400'(in_ready),  400'(0));
      in_valid = 1'b1;
      in_data  = 16'hDEAD;
      in_last  = 1'b1;
      tick();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    chk("bp_diag_zero", 400'(diag_zero), 400'(0));
    out_ready = 1'b1;
    tick();
    chk("bp_rel_out_valid", 400'(out_valid), 400'(0));
    chk("bp_rel_in_ready",  400'(in_ready),  400'(1));

    // Early last at k = 7
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) send(16'h0A00 + 16'(k), 1'b0);
    send(16'h0A07, 1'b1);
    chk("early_frame_err", 400'(frame_err), 400'(1));
    chk("early_out_valid", 400'(out_valid), 400'(0));
    tick();
    chk("early_frame_err_pulse", 400'(frame_err), 400'(0));
    for (int k = 0; k < 25; k++) elem[k] = 16'h0100 + 16'(k);
    build_exp();
    send_matrix(1'b1);
    chk("early_next_valid",  400'(out_valid),        400'(1));
    chk("early_next_el0",    400'(out_matrix[15:0]), 400'(16'h0100));
    chk("early_next_matrix", out_matrix,             exp_mat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Missing last: 25 elements, none flagged
    for (int k = 0; k < 25; k++) elem[k] = 16'h0B00 + 16'(k);
    send_matrix(1'b0);
    chk("miss_frame_err", 400'(frame_err), 400'(1));
    chk("miss_out_valid", 400'(out_valid), 400'(0));
    for (int k = 0; k < 25; k++) elem[k] = 16'h0200 + 16'(k);
    build_exp();
    send_matrix(1'b1);
    chk("miss_next_valid",     400'(out_valid), 400'(1));
    chk("miss_next_frame_err", 400'(frame_err), 400'(0));
    chk("miss_next_matrix",    out_matrix,      exp_mat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-fill at k = 12
    for (int k = 0; k < 12; k++) send(16'h0C00 + 16'(k), 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_in_ready",   400'(in_ready),  400'(0));
    chk("midrst_out_matrix", out_matrix,      '0);
    tick();
    reset = 1'b0;
    #1;
    for (int k = 0; k < 25; k++) elem[k] = 16'h0300 + 16'(k);
    build_exp();
    for (int k = 0; k < 24; k++) send(elem[k], 1'b0);
    chk("midrst_no_early_valid", 400'(out_valid), 400'(0));
    send(elem[24], 1'b1);
    chk("midrst_valid",  400'(out_valid), 400'(1));
    chk("midrst_matrix", out_matrix,      exp_mat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Zero pivot at element 12
    for (int k = 0; k < 25; k++) elem[k] = 16'(k + 1);
    elem[12] = 16'd0;
    build_exp();
`ifdef MATRIX_LOADER_DIAG_CHECK_EN
    exp_dz = 1'b1;
`else
    exp_dz = 1'b0;
`endif
    send_matrix(1'b1);
    chk("zp_out_valid", 400'(out_valid), 400'(1));
    chk("zp_matrix",    out_matrix,      exp_mat);
    chk("zp_diag_zero", 400'(diag_zero), 400'(exp_dz));
    tick();
    chk("zp_diag_zero_hold", 400'(diag_zero), 400'(exp_dz));
    out_ready = 1'b1;
    tick();
    chk("zp_hs_out_valid", 400'(out_valid), 400'(0));
    chk("zp_hs_diag_zero", 400'(diag_zero), 400'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
